// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type encodings and framing states.
package noc_pkg;

    localparam int unsigned FLIT_SIZE  = 16;
    localparam int unsigned HEADER_LEN = 2;
    localparam int unsigned PAYLOAD_W  = FLIT_SIZE - HEADER_LEN;

    typedef logic [FLIT_SIZE-1:0] flit_t;

    // Flit type lives in the top HEADER_LEN bits of every flit.
    typedef enum logic [HEADER_LEN-1:0] {
        FlitBody   = 2'b00,
        FlitHead   = 2'b01,
        FlitTail   = 2'b10,
        FlitSingle = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        StIdle,
        StInPkt
    } frame_state_e;

    function automatic flit_type_e flit_type(flit_t f);
        return flit_type_e'(f[FLIT_SIZE-1 -: HEADER_LEN]);
    endfunction

endpackage

// File: rtl/flit_fifo_mem.sv
// Flit storage array: synchronous write, asynchronous read, no reset.
module flit_fifo_mem
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [FLIT_SIZE-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [FLIT_SIZE-1:0] rdata_o
);

    flit_t mem_q [DEPTH];

    // Write port; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flit_input_buffer.sv
// Per-port flit FIFO in front of a reductor input: framing check, cut-through or
// store-and-forward presentation, valid/avail handshake on both sides.
module flit_input_buffer
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned STORE_FORWARD = 0,
    parameter int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [FLIT_SIZE-1:0] in_i,
    input  logic                 in_valid_i,
    output logic                 in_avail_o,
    output logic [FLIT_SIZE-1:0] out_o,
    output logic                 out_valid_o,
    input  logic                 out_avail_i,
    output logic [CNT_W-1:0]     occupancy_o,
    output logic                 pkt_err_o
);

    localparam int unsigned     PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, pkt_inc, pkt_dec;
    frame_state_e     state_q, state_d;
    logic             err_q, err_d, err_set;
    logic             out_in_pkt_q, out_in_pkt_d;
    logic             in_fire, wr_en, rd_en;
    flit_t            head_flit;
    flit_type_e       in_type, rd_type;

    // Handshake decoded from registered state only; no out_avail -> in_avail path.
    assign in_avail_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0) && ((STORE_FORWARD == 0) || (pkt_cnt_q != '0));
    assign out_o       = out_valid_o ? head_flit : '0;
    assign occupancy_o = count_q;
    assign pkt_err_o   = err_q;

    assign in_fire = in_valid_i && in_avail_o;
    assign rd_en   = out_valid_o && out_avail_i;
    assign in_type = flit_type(in_i);
    assign rd_type = flit_type(head_flit);

    flit_fifo_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_i),
        .raddr_i(rd_ptr_q),
        .rdata_o(head_flit)
    );

    // Input-side framing FSM: decides whether an accepted flit is stored.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        pkt_inc = '0;
        err_set = 1'b0;
        if (in_fire) begin
            unique case (state_q)
                StIdle: begin
                    case (in_type)
                        FlitHead: begin
                            wr_en   = 1'b1;
                            state_d = StInPkt;
                        end
                        FlitSingle: begin
                            wr_en   = 1'b1;
                            pkt_inc = ONE;
                        end
                        // Stray BODY/TAIL: swallowed, not stored.
                        default: err_set = 1'b1;
                    endcase
                end
                StInPkt: begin
                    case (in_type)
                        FlitBody: wr_en = 1'b1;
                        FlitTail: begin
                            wr_en   = 1'b1;
                            pkt_inc = ONE;
                            state_d = StIdle;
                        end
                        // New HEAD closes the open packet implicitly.
                        FlitHead: begin
                            wr_en   = 1'b1;
                            pkt_inc = ONE;
                            err_set = 1'b1;
                        end
                        // SINGLE closes the open packet and is itself complete.
                        default: begin
                            wr_en   = 1'b1;
                            pkt_inc = TWO;
                            err_set = 1'b1;
                            state_d = StIdle;
                        end
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output-side packet tracking: retire complete packets as their last flit leaves.
    always_comb begin
        pkt_dec      = '0;
        out_in_pkt_d = out_in_pkt_q;
        if (rd_en) begin
            case (rd_type)
                FlitHead: begin
                    if (out_in_pkt_q) begin
                        pkt_dec = ONE;
                    end
                    out_in_pkt_d = 1'b1;
                end
                FlitTail, FlitSingle: begin
                    pkt_dec      = ONE;
                    out_in_pkt_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Pointer, occupancy and packet-count next state.
    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        pkt_cnt_d = pkt_cnt_q + pkt_inc - pkt_dec;
        err_d     = err_q | err_set;
    end

    // State registers; reset drops all buffered flits at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_cnt_q    <= '0;
            state_q      <= StIdle;
            err_q        <= 1'b0;
            out_in_pkt_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_cnt_q    <= pkt_cnt_d;
            state_q      <= state_d;
            err_q        <= err_d;
            out_in_pkt_q <= out_in_pkt_d;
        end
    end

endmodule

// File: tb/tb_flit_input_buffer.sv
// Directed bench: one cut-through and one store-and-forward buffer, DEPTH=8.
module tb_flit_input_buffer;
    import noc_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;

    logic [FLIT_SIZE-1:0] ct_in, ct_out, sf_in, sf_out;
    logic                 ct_in_valid, ct_in_avail, ct_out_valid, ct_out_avail, ct_err;
    logic                 sf_in_valid, sf_in_avail, sf_out_valid, sf_out_avail, sf_err;
    logic [CNT_W-1:0]     ct_occ, sf_occ;

    int unsigned n_checks;
    int unsigned n_fail;
    flit_t       seq [4];

    flit_input_buffer #(
        .DEPTH        (DEPTH),
        .STORE_FORWARD(0)
    ) u_ct (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_i       (ct_in),
        .in_valid_i (ct_in_valid),
        .in_avail_o (ct_in_avail),
        .out_o      (ct_out),
        .out_valid_o(ct_out_valid),
        .out_avail_i(ct_out_avail),
        .occupancy_o(ct_occ),
        .pkt_err_o  (ct_err)
    );

    flit_input_buffer #(
        .DEPTH        (DEPTH),
        .STORE_FORWARD(1)
    ) u_sf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_i       (sf_in),
        .in_valid_i (sf_in_valid),
        .in_avail_o (sf_in_avail),
        .out_o      (sf_out),
        .out_valid_o(sf_out_valid),
        .out_avail_i(sf_out_avail),
        .occupancy_o(sf_occ),
        .pkt_err_o  (sf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(flit_type_e t, logic [PAYLOAD_W-1:0] p);
        return {t, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next active edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        ct_in        = '0;
        ct_in_valid  = 1'b0;
        ct_out_avail = 1'b0;
        sf_in        = '0;
        sf_in_valid  = 1'b0;
        sf_out_avail = 1'b0;
        #1;
        chk("rst_in_avail", ct_in_avail, 1);
        chk("rst_out_valid", ct_out_valid, 0);
        chk("rst_out", ct_out, 0);
        chk("rst_occ", ct_occ, 0);
        chk("rst_err", ct_err, 0);
        chk("rst_sf_out_valid", sf_out_valid, 0);
        #1 rst_n = 1'b1;

        // Cut-through single-flit latency.
        ct_out_avail = 1'b1;
        ct_in        = mk(FlitSingle, 14'h00A);
        ct_in_valid  = 1'b1;
        step();
        ct_in_valid = 1'b0;
        chk("ct_single_valid", ct_out_valid, 1);
        chk("ct_single_out", ct_out, mk(FlitSingle, 14'h00A));
        chk("ct_single_occ1", ct_occ, 1);
        step();
        chk("ct_single_occ0", ct_occ, 0);
        chk("ct_single_drained", ct_out_valid, 0);
        chk("ct_single_out0", ct_out, 0);

        // Fill to DEPTH with output blocked; pointers wrap during this.
        ct_out_avail = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ct_in       = (i == 0) ? mk(FlitHead, 14'h100) : mk(FlitBody, 14'(32'h100 + i));
            ct_in_valid = 1'b1;
            step();
        end
        chk("fill_in_avail", ct_in_avail, 0);
        chk("fill_occ", ct_occ, 8);
        chk("fill_head", ct_out, mk(FlitHead, 14'h100));
        ct_in = mk(FlitBody, 14'h108);
        step();
        chk("fill_held_occ", ct_occ, 8);
        ct_out_avail = 1'b1;
        step();
        ct_out_avail = 1'b0;
        chk("full_read_occ", ct_occ, 7);
        chk("full_read_avail", ct_in_avail, 1);
        chk("full_read_next", ct_out, mk(FlitBody, 14'h101));
        step();
        ct_in_valid = 1'b0;
        chk("ninth_written_occ", ct_occ, 8);
        chk("ninth_full_again", ct_in_avail, 0);
        ct_out_avail = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", ct_out, mk(FlitBody, 14'(32'h100 + i)));
            step();
        end
        chk("drain_occ", ct_occ, 0);
        chk("drain_valid", ct_out_valid, 0);
        ct_in       = mk(FlitTail, 14'h109);
        ct_in_valid = 1'b1;
        step();
        ct_in_valid = 1'b0;
        chk("fill_tail", ct_out, mk(FlitTail, 14'h109));
        step();
        chk("fill_tail_occ", ct_occ, 0);
        chk("fill_no_err", ct_err, 0);

        // BODY while idle is swallowed and flagged.
        ct_in       = mk(FlitBody, 14'h0AA);
        ct_in_valid = 1'b1;
        step();
        ct_in_valid = 1'b0;
        chk("ferr_occ", ct_occ, 0);
        chk("ferr_flag", ct_err, 1);
        chk("ferr_valid", ct_out_valid, 0);
        ct_in       = mk(FlitHead, 14'h0B1);
        ct_in_valid = 1'b1;
        step();
        chk("ferr_head", ct_out, mk(FlitHead, 14'h0B1));
        ct_in = mk(FlitTail, 14'h0B2);
        step();
        ct_in_valid = 1'b0;
        chk("ferr_tail", ct_out, mk(FlitTail, 14'h0B2));
        chk("ferr_tail_occ", ct_occ, 1);
        step();
        chk("ferr_occ_end", ct_occ, 0);
        chk("ferr_sticky", ct_err, 1);

        // Store-and-forward: nothing presented until the tail is in.
        sf_out_avail = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sf_in       = (i == 0) ? mk(FlitHead, 14'h200) : mk(FlitBody, 14'(32'h200 + i));
            sf_in_valid = 1'b1;
            step();
            chk("sf_wait_valid", sf_out_valid, 0);
        end
        sf_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sf_gap_valid", sf_out_valid, 0);
        end
        chk("sf_gap_occ", sf_occ, 3);
        sf_in       = mk(FlitTail, 14'h203);
        sf_in_valid = 1'b1;
        step();
        sf_in_valid = 1'b0;
        chk("sf_tail_valid", sf_out_valid, 1);
        chk("sf_out0", sf_out, mk(FlitHead, 14'h200));
        step();
        chk("sf_out1", sf_out, mk(FlitBody, 14'h201));
        step();
        chk("sf_out2", sf_out, mk(FlitBody, 14'h202));
        step();
        chk("sf_out3", sf_out, mk(FlitTail, 14'h203));
        step();
        chk("sf_empty_valid", sf_out_valid, 0);
        chk("sf_empty_occ", sf_occ, 0);

        // Implicit termination: HEAD inside an open packet closes it.
        sf_out_avail = 1'b0;
        chk("sf_no_err_yet", sf_err, 0);
        seq[0] = mk(FlitHead, 14'h300);
        seq[1] = mk(FlitBody, 14'h301);
        seq[2] = mk(FlitHead, 14'h302);
        seq[3] = mk(FlitTail, 14'h303);
        for (int i = 0; i < 4; i++) begin
            sf_in       = seq[i];
            sf_in_valid = 1'b1;
            step();
        end
        sf_in_valid = 1'b0;
        chk("impl_pkt_cnt", u_sf.pkt_cnt_q, 2);
        chk("impl_err", sf_err, 1);
        chk("impl_occ", sf_occ, 4);
        sf_out_avail = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("impl_valid", sf_out_valid, 1);
            chk("impl_out", sf_out, seq[i]);
            step();
        end
        chk("impl_occ_end", sf_occ, 0);
        chk("impl_pkt_cnt_end", u_sf.pkt_cnt_q, 0);
        chk("impl_valid_end", sf_out_valid, 0);

        // Asynchronous reset mid-packet.
        ct_out_avail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ct_in       = (i == 0) ? mk(FlitHead, 14'h400) : mk(FlitBody, 14'(32'h400 + i));
            ct_in_valid = 1'b1;
            step();
        end
        ct_in_valid = 1'b0;
        chk("arst_pre_occ", ct_occ, 5);
        chk("arst_pre_valid", ct_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ct_out_valid, 0);
        chk("arst_occ", ct_occ, 0);
        chk("arst_out", ct_out, 0);
        chk("arst_in_avail", ct_in_avail, 1);
        chk("arst_err", ct_err, 0);
        #1 rst_n = 1'b1;
        ct_out_avail = 1'b1;
        ct_in        = mk(FlitSingle, 14'h0C3);
        ct_in_valid  = 1'b1;
        step();
        ct_in_valid = 1'b0;
        chk("post_rst_valid", ct_out_valid, 1);
        chk("post_rst_out", ct_out, mk(FlitSingle, 14'h0C3));
        step();
        chk("post_rst_occ", ct_occ, 0);
        chk("post_rst_err", ct_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
